// File: rtl/btn_pkg.sv
// Shared types and helpers for the button gesture controller.
package btn_pkg;

    // Gesture FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Code reported on last_event for the most recent gesture.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        DOUBLE = 2'd2,
        LONG   = 2'd3
    } gesture_t;

    // Convert a duration in milliseconds into clock cycles.
    function automatic int unsigned ms_to_clks(input int unsigned clk_hz,
                                               input int unsigned ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/btn_gesture_ctrl_pulse_stretcher.sv
// Fixed-width pulse generator: a trigger starts a WIDTH_CYCLES-long pulse.
// Triggers arriving while the pulse is already running are ignored.
module pulse_stretcher #(
    parameter int unsigned WIDTH_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    output logic pulse
);

    localparam int CNT_W = $clog2(WIDTH_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // Down-counter: loads on trigger when idle, counts to zero and stops there.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else if (trig) begin
            cnt <= CNT_W'(WIDTH_CYCLES);
        end
    end

    assign pulse = (cnt != '0);

endmodule

// File: rtl/btn_gesture_ctrl.sv
// Button gesture recogniser: turns debounced click pulses and the long-press
// level into single / double / long-hold gesture pulses, and requests a
// fixed-width system reset on every long hold.
module btn_gesture_ctrl
    import btn_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY          = 100000000,
    parameter int unsigned DOUBLE_CLICK_WINDOW_MS = 1200,
    parameter int unsigned RST_PULSE_CYCLES       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       click,
    input  logic       long_press,
    output logic       single_click,
    output logic       double_click,
    output logic       long_hold,
    output logic       sys_rst,
    output logic [1:0] last_event,
    output logic       busy
);

    localparam int unsigned WINDOW_CLKS = ms_to_clks(CLK_FREQUENCY, DOUBLE_CLICK_WINDOW_MS);
    localparam int          TIMER_W     = $clog2(WINDOW_CLKS + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CLKS - 1);

    state_t             state;
    gesture_t           last_q;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_inc;
    logic               first_cycle;
    logic               long_fire;

    assign timer_inc = timer + TIMER_W'(1);

    // A long hold is decided on this cycle; a long_press already high on the
    // first cycle out of reset is a stale hold and must not fire.
    always_comb begin
        long_fire = 1'b0;
        if (!reset && long_press) begin
            if (state == WAIT1)
                long_fire = 1'b1;
            else if (state == IDLE && !first_cycle)
                long_fire = 1'b1;
        end
    end

    // Gesture FSM with window timer and registered gesture pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            first_cycle  <= 1'b1;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_hold    <= 1'b0;
            last_q       <= NONE;
        end else begin
            first_cycle  <= 1'b0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_hold    <= 1'b0;
            case (state)
                IDLE: begin
                    if (long_press) begin
                        state <= HOLD;
                        if (long_fire) begin
                            long_hold <= 1'b1;
                            last_q    <= LONG;
                        end
                    end else if (click) begin
                        state <= WAIT1;
                        timer <= '0;
                    end
                end
                WAIT1: begin
                    timer <= timer_inc;
                    if (long_press) begin
                        state     <= HOLD;
                        long_hold <= 1'b1;
                        last_q    <= LONG;
                    end else if (click) begin
                        state        <= IDLE;
                        double_click <= 1'b1;
                        last_q       <= DOUBLE;
                    end else if (timer_inc == TIMER_LAST) begin
                        state        <= IDLE;
                        single_click <= 1'b1;
                        last_q       <= SINGLE;
                    end
                end
                HOLD: begin
                    if (!long_press)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    pulse_stretcher #(
        .WIDTH_CYCLES(RST_PULSE_CYCLES)
    ) u_rst_stretch (
        .clk  (clk),
        .reset(reset),
        .trig (long_fire),
        .pulse(sys_rst)
    );

    assign last_event = last_q;
    assign busy       = (state != IDLE) || sys_rst;

endmodule

// File: tb/tb_btn_gesture_ctrl.sv
// Bench for btn_gesture_ctrl: directed gesture scenarios plus random
// click / long-press / reset traffic against a timestamp-based reference.
module tb_btn_gesture_ctrl;

    localparam int CLK_HZ = 10000;
    localparam int WIN_MS = 5;
    localparam int RSTC   = 4;
    localparam int WIN    = CLK_HZ / 1000 * WIN_MS;

    logic       clk = 1'b0;
    logic       reset, click, long_press;
    logic       single_click, double_click, long_hold, sys_rst, busy;
    logic [1:0] last_event;

    btn_gesture_ctrl #(
        .CLK_FREQUENCY(CLK_HZ),
        .DOUBLE_CLICK_WINDOW_MS(WIN_MS),
        .RST_PULSE_CYCLES(RSTC)
    ) dut (
        .clk(clk), .reset(reset), .click(click), .long_press(long_press),
        .single_click(single_click), .double_click(double_click),
        .long_hold(long_hold), .sys_rst(sys_rst),
        .last_event(last_event), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = -1;

    // Reference model: first-click timestamp, hold flag, sys_rst interval.
    int pend_at  = -1;
    bit holding  = 0;
    bit after_rst = 1;
    int rst_from = 0;
    int rst_to   = -10;
    logic e_s = 0, e_d = 0, e_l = 0, e_rst = 0, e_busy = 0;
    logic [1:0] e_last = 0;

    // Scenario trackers, indexed relative to scenario start.
    int base;
    int t_single_n, t_single_at, t_double_n, t_double_at;
    int t_long_n, t_long_at, t_rst_n, t_rst_first, t_rst_last;
    logic busy_log [0:255];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit c, input bit lp);
        bit fire;
        int nxt;
        e_s = 0; e_d = 0; e_l = 0;
        fire = 0;
        if (r) begin
            pend_at = -1; holding = 0; after_rst = 1;
            rst_from = 0; rst_to = -10; e_last = 0;
        end else begin
            if (holding) begin
                if (!lp) holding = 0;
            end else if (pend_at >= 0) begin
                if (lp) begin
                    fire = 1; pend_at = -1; holding = 1;
                end else if (c) begin
                    e_d = 1; e_last = 2; pend_at = -1;
                end else if (cyc - pend_at == WIN - 1) begin
                    e_s = 1; e_last = 1; pend_at = -1;
                end
            end else begin
                if (lp) begin
                    holding = 1;
                    if (!after_rst) fire = 1;
                end else if (c) begin
                    pend_at = cyc;
                end
            end
            after_rst = 0;
            if (fire) begin
                e_l = 1; e_last = 3;
                if (!(cyc >= rst_from && cyc <= rst_to)) begin
                    rst_from = cyc + 1;
                    rst_to   = cyc + RSTC;
                end
            end
        end
        nxt    = cyc + 1;
        e_rst  = (nxt >= rst_from) && (nxt <= rst_to);
        e_busy = holding || (pend_at >= 0) || e_rst;
    endtask

    task automatic step(input bit r, input bit c, input bit lp);
        int rel;
        @(posedge clk);
        #1;
        cyc++;
        chk("single_click", single_click, e_s);
        chk("double_click", double_click, e_d);
        chk("long_hold",    long_hold,    e_l);
        chk("sys_rst",      sys_rst,      e_rst);
        chk("last_event",   last_event,   e_last);
        chk("busy",         busy,         e_busy);
        rel = cyc - base;
        if (rel >= 0 && rel < 256) busy_log[rel] = busy;
        if (single_click) begin t_single_n++; t_single_at = rel; end
        if (double_click) begin t_double_n++; t_double_at = rel; end
        if (long_hold)    begin t_long_n++;   t_long_at   = rel; end
        if (sys_rst) begin
            if (t_rst_n == 0) t_rst_first = rel;
            t_rst_n++;
            t_rst_last = rel;
        end
        reset = r; click = c; long_press = lp;
        model(r, c, lp);
    endtask

    task automatic begin_scn();
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        base = cyc + 1;
        t_single_n = 0; t_single_at = -1; t_double_n = 0; t_double_at = -1;
        t_long_n = 0; t_long_at = -1; t_rst_n = 0; t_rst_first = -1; t_rst_last = -1;
        for (int i = 0; i < 256; i++) busy_log[i] = 1'bx;
    endtask

    initial begin
        bit lp_r;
        reset = 1; click = 0; long_press = 0;

        // Single click resolves at window end.
        begin_scn();
        for (int k = 0; k < 80; k++) step(0, k == 10, 0);
        chk("s1_single_n",  t_single_n, 1);
        chk("s1_single_at", t_single_at, 60);
        chk("s1_last",      last_event, 1);
        chk("s1_busy61",    busy_log[61], 0);

        // Double click.
        begin_scn();
        for (int k = 0; k < 80; k++) step(0, k == 10 || k == 30, 0);
        chk("s2_double_at", t_double_at, 31);
        chk("s2_single_n",  t_single_n, 0);
        chk("s2_last",      last_event, 2);

        // Long hold from WAIT1, click during hold ignored.
        begin_scn();
        for (int k = 0; k < 110; k++) step(0, k == 10 || k == 70, k >= 40 && k <= 99);
        chk("s3_long_at",   t_long_at, 41);
        chk("s3_rst_first", t_rst_first, 41);
        chk("s3_rst_last",  t_rst_last, 44);
        chk("s3_rst_n",     t_rst_n, 4);
        chk("s3_dbl_n",     t_double_n, 0);
        chk("s3_busy100",   busy_log[100], 1);
        chk("s3_busy101",   busy_log[101], 0);

        // Click and long_press together at window edge: long wins.
        begin_scn();
        for (int k = 0; k < 90; k++) step(0, k == 10 || k == 59, k >= 59 && k <= 70);
        chk("s4_long_at",   t_long_at, 60);
        chk("s4_dbl_n",     t_double_n, 0);
        chk("s4_single_n",  t_single_n, 0);

        // Click alone at window edge: double, not single.
        begin_scn();
        for (int k = 0; k < 90; k++) step(0, k == 10 || k == 59, 0);
        chk("s5_double_at", t_double_at, 60);
        chk("s5_single_n",  t_single_n, 0);

        // Reset in WAIT1 aborts the pending single click.
        begin_scn();
        for (int k = 0; k < 100; k++) step(k == 20, k == 10, 0);
        chk("s6_single_n",  t_single_n, 0);
        chk("s6_busy21",    busy_log[21], 0);
        chk("s6_last",      last_event, 0);

        // Reset during sys_rst truncates it; stale long_press does not refire.
        begin_scn();
        for (int k = 0; k < 90; k++) step(k == 42, k == 10, k >= 40 && k <= 60);
        chk("s7_rst_n",     t_rst_n, 2);
        chk("s7_long_n",    t_long_n, 1);
        chk("s7_busy43",    busy_log[43], 0);
        chk("s7_busy44",    busy_log[44], 1);
        chk("s7_busy62",    busy_log[62], 0);

        // Release from reset with long_press held.
        begin_scn();
        for (int k = 0; k < 40; k++) step(k < 5, 0, k < 20);
        chk("s8_long_n",    t_long_n, 0);
        chk("s8_busy6",     busy_log[6], 1);
        chk("s8_busy20",    busy_log[20], 1);
        chk("s8_busy21",    busy_log[21], 0);

        // Random traffic.
        lp_r = 0;
        for (int i = 0; i < 4000; i++) begin
            if (lp_r) lp_r = ($urandom_range(0, 29) != 0);
            else      lp_r = ($urandom_range(0, 79) == 0);
            step($urandom_range(0, 399) == 0, $urandom_range(0, 14) == 0, lp_r);
        end
        step(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
